mmio_hub: RTL and testbench
===========================

# mmio_hub

Parametrised memory-mapped I/O hub between the processor data port and data RAM. Decodes a configurable I/O window out of the data address space, routes other accesses to RAM, and provides button capture, a GPIO output register, and a programmable tick generator with a tick counter. Returns read data with the same one-cycle latency as the synchronous RAM, so the processor sees a single uniform data memory.

## Interface

**Parameters**
- ADDR_WIDTH, 12: data address width.
- DATA_WIDTH, 32: data word width; must be ≥ 16.
- NUM_BTN, 5: button channels, 1..16.
- GPIO_WIDTH, 16: GPIO output bits, ≤ DATA_WIDTH.
- IO_BASE, 12'hF00: first I/O word address; the window is IO_BASE..IO_BASE+7.
- DIV_WIDTH, 16: tick divider width.
- DB_BITS, 4: debounce window is 2^DB_BITS cycles; used only with the debounce macro.

**Ports**
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- cpu_addr, input, ADDR_WIDTH: data address.
- cpu_wdata, input, DATA_WIDTH: write data.
- cpu_wen, input, 1: write enable.
- cpu_rdata, output, DATA_WIDTH: read data, valid one cycle after the address.
- ram_wen, output, 1: RAM write enable; equals cpu_wen when the address is outside the window.
- ram_rdata, input, DATA_WIDTH: synchronous RAM output.
- btn_in, input, NUM_BTN: raw asynchronous buttons.
- gpio_out, output, GPIO_WIDTH: GPIO register contents.
- tick, output, 1: one-cycle strobe from the divider.
- irq, output, 1: high while any enabled button-press bit is set.

## Operation

**Decode**
- io_sel = (cpu_addr ≥ IO_BASE) && (cpu_addr < IO_BASE+8). Word offset is cpu_addr − IO_BASE.
- ram_wen = cpu_wen & ~io_sel (combinational).

**Register map (word offsets)**
- 0 BTN_LEVEL, RO: synchronised (or debounced) button levels, zero-extended.
- 1 BTN_PRESS, W1C: sticky rising-edge flags.
- 2 GPIO, RW: low GPIO_WIDTH bits are stored; the rest read as 0.
- 3 DIV_RELOAD, RW: low DIV_WIDTH bits are stored.
- 4 TICK_COUNT, RO: counts ticks and wraps at 2^DATA_WIDTH. Any write clears it.
- 5 IRQ_MASK, RW: low NUM_BTN bits are stored.
- 6 STATUS, RO: bit0 = irq, bit1 = DEBOUNCE_EN compiled in, bits[15:8] = NUM_BTN.
- 7 reserved: reads 0, writes are ignored.

**Buttons**
- Each input passes through a 2-flop synchroniser.
- A rising edge of the filtered level sets the matching BTN_PRESS bit.
- If a W1C write and a new edge hit the same bit in the same cycle, the bit stays set (the edge wins).

**Divider**
- div_cnt counts down from DIV_RELOAD.
- When div_cnt = 0: tick=1 for one cycle, div_cnt reloads, TICK_COUNT increments.
- DIV_RELOAD=0 gives tick every cycle. A write to DIV_RELOAD also reloads div_cnt on the next edge.
- If a TICK_COUNT write and a tick occur in the same cycle, TICK_COUNT becomes 1.

**irq**
- irq = |(BTN_PRESS & IRQ_MASK), combinational from registers.

## Timing

- Reset values: every register, div_cnt and the synchroniser flops are 0. Outputs during reset: gpio_out=0, tick=0, irq=0, cpu_rdata=0.
- Read path: io_sel and the offset are registered at edge N, and the I/O read data is registered at edge N. At N+1, cpu_rdata = registered io_sel ? io_data_q : ram_rdata.
- Writes take effect at the edge where cpu_wen is sampled. A read of the same register on the next cycle returns the new value.
- Button latency from btn_in to BTN_PRESS set: 3 edges without the macro (2 synchroniser edges plus 1 edge-detect edge).
- Reset asserted mid-operation clears all state immediately; the first tick after release comes DIV_RELOAD+1 cycles later (i.e. 1 cycle, since DIV_RELOAD resets to 0).

## Configuration

- MMIO_HUB_DEBOUNCE_EN defined:
  - Each channel gets a DB_BITS-wide counter.
  - The filtered level changes only after the synchronised input has differed from it for 2^DB_BITS consecutive cycles; the counter clears whenever the inputs agree.
  - Added latency: 2^DB_BITS cycles.
  - STATUS bit1 = 1.
- Undefined: the filtered level equals the synchroniser output; STATUS bit1 = 0.

## Structure

- Shared package `mmio_pkg`:
  - register offset constants (OFF_BTN_LEVEL … OFF_STATUS);
  - STATUS bit positions;
  - the typedef for the register-offset enum.
- One sub-module, `btn_filter`: a single channel containing the synchroniser, optional debounce, and rising-edge pulse output. It is instantiated NUM_BTN times with a generate loop.
- The divider, register file and read mux stay in mmio_hub.

## Test plan

- Decode: write 32'hDEADBEEF to address 12'h010 → ram_wen=1. Write to 12'hF02 → ram_wen=0 and gpio_out=16'hBEEF. Read 12'hF02 → cpu_rdata=32'h0000BEEF one cycle later.
- Button: pulse btn_in[2] high for 20 cycles (without the macro) → BTN_PRESS=32'h4 after 3 edges. With IRQ_MASK=4, irq=1. Writing 4 to offset 1 → irq=0 next cycle.
- W1C collision: issue a W1C of bit0 in the same cycle as a new edge on btn 0 → BTN_PRESS[0] remains 1.
- Divider: DIV_RELOAD=3 → tick every 4 cycles. After 40 cycles TICK_COUNT=10. A write to TICK_COUNT on a tick cycle → reads 1.
- Debounce (macro on, DB_BITS=4): a 10-cycle glitch causes no BTN_PRESS; a 20-cycle press sets BTN_PRESS 2+16+1 edges after the input rises. STATUS=32'h0502 | irq.
- Reset mid-run: assert reset with GPIO=16'h00FF and TICK_COUNT=7 → gpio_out=0 and TICK_COUNT reads 0 after release.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_hub shared definitions: register offsets and STATUS layout.
// Optional build macro: MMIO_HUB_DEBOUNCE_EN (per-button debounce filter).
package mmio_pkg;

    localparam int IO_WORDS = 8;

    typedef enum logic [2:0] {
        OFF_BTN_LEVEL  = 3'd0,
        OFF_BTN_PRESS  = 3'd1,
        OFF_GPIO       = 3'd2,
        OFF_DIV_RELOAD = 3'd3,
        OFF_TICK_COUNT = 3'd4,
        OFF_IRQ_MASK   = 3'd5,
        OFF_STATUS     = 3'd6,
        OFF_RESERVED   = 3'd7
    } reg_off_e;

    localparam int STATUS_IRQ_BIT  = 0;
    localparam int STATUS_DB_BIT   = 1;
    localparam int STATUS_NBTN_LSB = 8;
    localparam int STATUS_NBTN_MSB = 15;

endpackage

// File: rtl/mmio_hub_btn_filter.sv
// One button channel: 2-flop synchroniser, optional debounce, rising-edge pulse.
// Optional build macro: MMIO_HUB_DEBOUNCE_EN.
module btn_filter #(
    parameter int DB_BITS = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    // bring the raw asynchronous input into the clock domain
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef MMIO_HUB_DEBOUNCE_EN
    logic [DB_BITS-1:0] r_db_cnt;
    logic               r_db_level;

    // flip the level only after 2^DB_BITS consecutive disagreeing cycles
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
        end else if (r_sync2 == r_db_level) begin
            r_db_cnt <= '0;
        end else if (&r_db_cnt) begin
            r_db_cnt   <= '0;
            r_db_level <= r_sync2;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_level = r_db_level;
`else
    localparam int LP_UNUSED_DB = DB_BITS;

    assign w_level = r_sync2;
`endif

    // remember last filtered level for edge detection
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: window decode, buttons, GPIO, tick divider.
// Optional build macro: MMIO_HUB_DEBOUNCE_EN (debounced button levels).
module mmio_hub
    import mmio_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_BTN    = 5,
    parameter int                    GPIO_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 12'hF00,
    parameter int                    DIV_WIDTH  = 16,
    parameter int                    DB_BITS    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_wen,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  ram_wen,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic [NUM_BTN-1:0]    btn_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  tick,
    output logic                  irq
);

`ifdef MMIO_HUB_DEBOUNCE_EN
    localparam logic LP_DB_EN = 1'b1;
`else
    localparam logic LP_DB_EN = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] w_diff;
    logic                  w_io_sel;
    reg_off_e              w_off;
    logic                  w_we;
    logic [NUM_BTN-1:0]    w_level;
    logic [NUM_BTN-1:0]    w_rise;
    logic [NUM_BTN-1:0]    w_w1c;
    logic                  w_tick_evt;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_io_rdata;
    logic                  w_unused;

    logic [NUM_BTN-1:0]    r_press;
    logic [NUM_BTN-1:0]    r_mask;
    logic [GPIO_WIDTH-1:0] r_gpio;
    logic [DIV_WIDTH-1:0]  r_reload;
    logic [DIV_WIDTH-1:0]  r_div_cnt;
    logic [DATA_WIDTH-1:0] r_tcnt;
    logic                  r_tick;
    logic                  r_io_sel;
    logic [DATA_WIDTH-1:0] r_io_q;

    // unsigned wrap makes a single compare cover both window bounds
    assign w_diff   = cpu_addr - IO_BASE;
    assign w_io_sel = (w_diff < ADDR_WIDTH'(IO_WORDS));
    assign w_off    = reg_off_e'(w_diff[2:0]);
    assign w_we     = cpu_wen & w_io_sel;
    assign ram_wen  = cpu_wen & ~w_io_sel;

    // data bits above the widest stored field are never consumed
    assign w_unused = ^cpu_wdata;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_filter #(
            .DB_BITS(DB_BITS)
        ) u_filt (
            .i_clock(clock),
            .i_reset(reset),
            .i_raw  (btn_in[g]),
            .o_level(w_level[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_w1c = (w_we && w_off == OFF_BTN_PRESS)
                 ? cpu_wdata[NUM_BTN-1:0] : '0;
    assign irq   = |(r_press & r_mask);

    // software-writable registers; a fresh edge beats a same-cycle W1C
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_press  <= '0;
            r_mask   <= '0;
            r_gpio   <= '0;
            r_reload <= '0;
        end else begin
            r_press <= (r_press & ~w_w1c) | w_rise;
            if (w_we && w_off == OFF_GPIO)
                r_gpio <= cpu_wdata[GPIO_WIDTH-1:0];
            if (w_we && w_off == OFF_DIV_RELOAD)
                r_reload <= cpu_wdata[DIV_WIDTH-1:0];
            if (w_we && w_off == OFF_IRQ_MASK)
                r_mask <= cpu_wdata[NUM_BTN-1:0];
        end
    end

    assign w_tick_evt = (r_div_cnt == '0);

    // countdown divider, registered tick strobe and tick counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            r_tick <= w_tick_evt;
            if (w_we && w_off == OFF_DIV_RELOAD)
                r_div_cnt <= cpu_wdata[DIV_WIDTH-1:0];
            else if (w_tick_evt)
                r_div_cnt <= r_reload;
            else
                r_div_cnt <= r_div_cnt - 1'b1;
            if (w_we && w_off == OFF_TICK_COUNT)
                r_tcnt <= w_tick_evt ? DATA_WIDTH'(1) : '0;
            else if (w_tick_evt)
                r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // STATUS word assembly
    always_comb begin
        w_status = '0;
        w_status[STATUS_IRQ_BIT] = irq;
        w_status[STATUS_DB_BIT]  = LP_DB_EN;
        w_status[STATUS_NBTN_MSB:STATUS_NBTN_LSB] = 8'(NUM_BTN);
    end

    // I/O register read mux
    always_comb begin
        w_io_rdata = '0;
        unique case (w_off)
            OFF_BTN_LEVEL:  w_io_rdata[NUM_BTN-1:0]    = w_level;
            OFF_BTN_PRESS:  w_io_rdata[NUM_BTN-1:0]    = r_press;
            OFF_GPIO:       w_io_rdata[GPIO_WIDTH-1:0] = r_gpio;
            OFF_DIV_RELOAD: w_io_rdata[DIV_WIDTH-1:0]  = r_reload;
            OFF_TICK_COUNT: w_io_rdata                 = r_tcnt;
            OFF_IRQ_MASK:   w_io_rdata[NUM_BTN-1:0]    = r_mask;
            OFF_STATUS:     w_io_rdata                 = w_status;
            OFF_RESERVED:   w_io_rdata                 = '0;
            default:        w_io_rdata                 = '0;
        endcase
    end

    // align I/O read data with the synchronous RAM latency
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_io_sel <= 1'b0;
            r_io_q   <= '0;
        end else begin
            r_io_sel <= w_io_sel;
            r_io_q   <= w_io_rdata;
        end
    end

    assign cpu_rdata = reset ? '0 : (r_io_sel ? r_io_q : ram_rdata);
    assign gpio_out  = r_gpio;
    assign tick      = r_tick;

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub with an expected-value queue.
// Honours MMIO_HUB_DEBOUNCE_EN for button latency and STATUS bit1.
module tb_mmio_hub;

`ifdef MMIO_HUB_DEBOUNCE_EN
    localparam int          LAT = 19;
    localparam logic [31:0] DBS = 32'h2;
`else
    localparam int          LAT = 3;
    localparam logic [31:0] DBS = 32'h0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_wen;
    logic [31:0] cpu_rdata;
    logic        ram_wen;
    logic [31:0] ram_rdata;
    logic [4:0]  btn_in;
    logic [15:0] gpio_out;
    logic        tick;
    logic        irq;

    logic [31:0] mem [0:15];
    logic [31:0] exp_q [$];
    logic [31:0] got;
    logic [31:0] exp_v;
    int          checks = 0;
    int          errors = 0;

    mmio_hub dut (
        .clock    (clock),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_wen  (cpu_wen),
        .cpu_rdata(cpu_rdata),
        .ram_wen  (ram_wen),
        .ram_rdata(ram_rdata),
        .btn_in   (btn_in),
        .gpio_out (gpio_out),
        .tick     (tick),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    // tiny synchronous RAM behind the hub
    always @(posedge clock) begin
        if (ram_wen) mem[cpu_addr[3:0]] <= cpu_wdata;
        ram_rdata <= mem[cpu_addr[3:0]];
    end

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wen   = 1'b1;
        @(negedge clock);
        cpu_wen = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        cpu_addr = a;
        cpu_wen  = 1'b0;
        @(negedge clock);
        d = cpu_rdata;
    endtask

    task automatic idle(input int n);
        cpu_wen  = 1'b0;
        cpu_addr = 12'h000;
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        logic [11:0] ra [7];
        ra = '{12'hF00, 12'hF01, 12'hF02, 12'hF03,
               12'hF05, 12'hF06, 12'hF07};
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (gpio_out !== 16'h0 || tick !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs gpio=%h tick=%b irq=%b want 0",
                     gpio_out, tick, irq);
        end
        checks++;
        if (cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", cpu_rdata);
        end
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(i == 5 ? (32'h500 | DBS) : 32'h0);
            rd(ra[i], got);
            if (i == 0) begin
                checks++;
                if (tick !== 1'b1) begin
                    errors++;
                    $display("FAIL first_tick got %b want 1", tick);
                end
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_reg %h got %h want %h",
                         ra[i], got, exp_v);
            end
        end
    endtask

    task automatic test_decode;
        logic [11:0] wa [5];
        logic        we [5];
        wa = '{12'h010, 12'hF02, 12'hF07, 12'hF08, 12'hEFF};
        we = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            cpu_addr  = wa[i];
            cpu_wdata = (i == 0 || i == 1) ? 32'hDEADBEEF : 32'h1234_5678;
            cpu_wen   = 1'b1;
            #1;
            checks++;
            if (ram_wen !== we[i]) begin
                errors++;
                $display("FAIL ram_wen addr %h got %b want %b",
                         wa[i], ram_wen, we[i]);
            end
            @(negedge clock);
            cpu_wen = 1'b0;
        end
        checks++;
        if (gpio_out !== 16'hBEEF) begin
            errors++;
            $display("FAIL gpio_out got %h want BEEF", gpio_out);
        end
        exp_q.push_back(32'h0000BEEF);
        rd(12'hF02, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL gpio_read got %h want %h", got, exp_v);
        end
        exp_q.push_back(32'hDEADBEEF);
        rd(12'h010, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL ram_read got %h want %h", got, exp_v);
        end
        exp_q.push_back(32'h0);
        rd(12'hF07, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reserved_read got %h want %h", got, exp_v);
        end
    endtask

    task automatic test_button;
        wr(12'hF05, 32'h4);
        btn_in[2] = 1'b1;
        repeat (LAT - 1) @(negedge clock);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL btn_early irq got %b want 0", irq);
        end
        @(negedge clock);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL btn_irq got %b want 1", irq);
        end
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h501 | DBS);
        rd(12'hF01, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL btn_press got %h want %h", got, exp_v);
        end
        rd(12'hF00, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL btn_level got %h want %h", got, exp_v);
        end
        rd(12'hF06, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL status_irq got %h want %h", got, exp_v);
        end
        wr(12'hF01, 32'h4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_irq got %b want 0", irq);
        end
        idle(13);
        btn_in[2] = 1'b0;
        idle(LAT + 2);
        exp_q.push_back(32'h0);
        rd(12'hF01, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL btn_release got %h want %h", got, exp_v);
        end
    endtask

    task automatic test_w1c_collision;
        btn_in[0] = 1'b1;
        idle(LAT + 1);
        btn_in[0] = 1'b0;
        idle(LAT + 2);
        btn_in[0] = 1'b1;
        repeat (LAT - 1) @(negedge clock);
        wr(12'hF01, 32'h1);
        exp_q.push_back(32'h1);
        rd(12'hF01, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL w1c_collision got %h want %h", got, exp_v);
        end
        wr(12'hF01, 32'h1);
        exp_q.push_back(32'h0);
        rd(12'hF01, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL w1c_plain got %h want %h", got, exp_v);
        end
        btn_in[0] = 1'b0;
        idle(LAT + 2);
    endtask

    task automatic test_back_to_back;
        logic [11:0] ra [6];
        ra = '{12'hF05, 12'hF03, 12'hF02, 12'h010, 12'hF07, 12'hF06};
        wr(12'hF05, 32'hFFFF_FFFF);
        wr(12'hF03, 32'hFFFF_FFFF);
        wr(12'hF07, 32'hFFFF_FFFF);
        exp_q.push_back(32'h1F);
        exp_q.push_back(32'hFFFF);
        exp_q.push_back(32'hBEEF);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h500 | DBS);
        for (int i = 0; i < 6; i++) begin
            rd(ra[i], got);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL b2b %h got %h want %h", ra[i], got, exp_v);
            end
        end
    endtask

    task automatic test_divider;
        int nt;
        nt = 0;
        wr(12'hF03, 32'h3);
        wr(12'hF04, 32'h0);
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (tick === 1'b1) nt++;
        end
        checks++;
        if (nt != 10) begin
            errors++;
            $display("FAIL tick_strobes got %0d want 10", nt);
        end
        exp_q.push_back(32'd10);
        rd(12'hF04, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL tick_count got %h want %h", got, exp_v);
        end
        idle(1);
        wr(12'hF04, 32'h0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd3);
        rd(12'hF04, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL tcnt_collision got %h want %h", got, exp_v);
        end
        rd(12'hF03, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL div_reload got %h want %h", got, exp_v);
        end
    endtask

`ifdef MMIO_HUB_DEBOUNCE_EN
    task automatic test_debounce_glitch;
        btn_in[1] = 1'b1;
        idle(10);
        btn_in[1] = 1'b0;
        idle(40);
        exp_q.push_back(32'h0);
        rd(12'hF01, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL glitch_press got %h want %h", got, exp_v);
        end
    endtask
`endif

    task automatic test_reset_midrun;
        wr(12'hF02, 32'h00FF);
        wr(12'hF03, 32'h0);
        wr(12'hF04, 32'h0);
        idle(6);
        exp_q.push_back(32'd7);
        rd(12'hF04, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL pre_reset_tcnt got %h want %h", got, exp_v);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (gpio_out !== 16'h0 || tick !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reset gpio=%h tick=%b rdata=%h want 0",
                     gpio_out, tick, cpu_rdata);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd(12'hF04, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL post_reset_tcnt got %h want %h", got, exp_v);
        end
        rd(12'hF02, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v || gpio_out !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_gpio got %h/%h want 0", got, gpio_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        cpu_addr  = 12'h000;
        cpu_wdata = 32'h0;
        cpu_wen   = 1'b0;
        btn_in    = 5'h0;
        test_reset();
        test_decode();
        test_button();
        test_w1c_collision();
        test_back_to_back();
        test_divider();
`ifdef MMIO_HUB_DEBOUNCE_EN
        test_debounce_glitch();
`endif
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
